// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared definitions for the clocked data memory controller.
//   WORD_W          - width of one memory word
//   SZ_*            - RISC-V funct3 load/store size codes
//   state_e         - controller FSM states (INIT sweep, RUN service)
package data_mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response port of the data memory.
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both 1. The requester holds req_* stable while req_valid is
//   high. rsp_valid pulses for exactly one cycle, one cycle after the transfer;
//   there is no response back-pressure.
//   master - execute-stage side (drives req_*, receives rsp_*)
//   slave  - memory side
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 9
);
    import data_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane steering for sub-word accesses.
//   size  in  - funct3 size code
//   lane  in  - byte address bits [1:0]
//   wdata in  - right-aligned store data
//   rword in  - word currently stored at the addressed index
//   be    out - byte enables for the store
//   wword out - store data replicated onto every candidate lane
//   rdata out - addressed lane shifted down and sign/zero extended
//   err   out - misaligned access or unsupported size code
module dm_lane_align
    import data_mem_pkg::*;
(
    input  logic [2:0]        size,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rword,
    output logic [3:0]        be,
    output logic [WORD_W-1:0] wword,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rword[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? rword[31:16] : rword[15:0];

    // Replicating the store data onto all lanes means the byte enables alone
    // decide which lanes land in the array.
    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        rdata = '0;
        err   = 1'b0;
        case (size)
            SZ_B, SZ_BU: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
                rdata = (size == SZ_B) ? {{24{sel_byte[7]}}, sel_byte}
                                       : {24'h000000, sel_byte};
            end
            SZ_H, SZ_HU: begin
                err   = lane[0];
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                rdata = (size == SZ_H) ? {{16{sel_half[15]}}, sel_half}
                                       : {16'h0000, sel_half};
            end
            SZ_W: begin
                err   = (lane != 2'b00);
                be    = 4'b1111;
                rdata = rword;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: DEPTH x 32-bit data memory behind a byte-addressed
// valid/ready port, with RISC-V sub-word loads/stores and a post-reset
// initialisation sweep.
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   bus         - request/response port (slave side)
//   init_done   - 1 once the sweep has written every word
//   dbg_state   - current FSM state
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 9,
    parameter int INIT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_ctrl_if.slave   bus,
    output logic             init_done,
    output state_e           dbg_state
);

    localparam int                 IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-2:0]  DEPTH_X  = (ADDR_W - 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    state_e            state;
    logic [IDX_W-1:0]  sweep_ptr;

    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [WORD_W-1:0] rword;
    logic [3:0]        be;
    logic [WORD_W-1:0] wword;
    logic [WORD_W-1:0] ld_data;
    logic              align_err;
    logic              range_err;
    logic              store_sz_err;
    logic              req_err;
    logic              accept;
    logic              wr_en;
    logic [WORD_W-1:0] fill_word;

    assign word_idx     = bus.req_addr[ADDR_W-1:2];
    assign rd_idx       = word_idx[IDX_W-1:0];
    assign rword        = mem[rd_idx];
    // Compare with one extra bit so DEPTH == 2**(ADDR_W-2) still fits.
    assign range_err    = ({1'b0, word_idx} >= DEPTH_X);
    assign store_sz_err = bus.req_we && (bus.req_size == SZ_BU || bus.req_size == SZ_HU);
    assign req_err      = align_err || range_err || store_sz_err;
    assign accept       = bus.req_valid && bus.req_ready;
    assign wr_en        = accept && bus.req_we && !req_err;
    assign fill_word    = (INIT_MODE != 0) ? WORD_W'(sweep_ptr) : '0;
    assign dbg_state    = state;

    dm_lane_align u_lane_align (
        .size  (bus.req_size),
        .lane  (bus.req_addr[1:0]),
        .wdata (bus.req_wdata),
        .rword (rword),
        .be    (be),
        .wword (wword),
        .rdata (ld_data),
        .err   (align_err)
    );

    // Array has no reset: after every reset the sweep rewrites it.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[sweep_ptr] <= fill_word;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[rd_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            sweep_ptr     <= '0;
            init_done     <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    if (sweep_ptr == LAST_IDX) begin
                        state         <= ST_RUN;
                        init_done     <= 1'b1;
                        bus.req_ready <= 1'b1;
                    end else begin
                        sweep_ptr <= sweep_ptr + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    bus.rsp_valid <= accept;
                    bus.rsp_err   <= accept && req_err;
                    bus.rsp_rdata <= (accept && !req_err && !bus.req_we) ? ld_data : '0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed bench for data_mem_ctrl.
//   u_dut   - DEPTH=128, ADDR_W=10, INIT_MODE=1 (main target)
//   u_small - DEPTH=16,  ADDR_W=7,  INIT_MODE=0 (zero-fill and range edge)
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    localparam int DEPTH    = 128;
    localparam int ADDR_W   = 10;
    localparam int S_DEPTH  = 16;
    localparam int S_ADDR_W = 7;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W))   bus ();
    data_mem_ctrl_if #(.ADDR_W(S_ADDR_W)) sbus ();

    logic   init_done, s_init_done;
    state_e dbg_state, s_dbg_state;

    data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_MODE(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done),
        .dbg_state (dbg_state)
    );

    data_mem_ctrl #(.DEPTH(S_DEPTH), .ADDR_W(S_ADDR_W), .INIT_MODE(0)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (sbus.slave),
        .init_done (s_init_done),
        .dbg_state (s_dbg_state)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [DEPTH];
    logic [32:0] exp_q [$];   // {err, rdata}
    logic [32:0] mon_e;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = i;
    endtask

    function automatic logic [32:0] model_access(input logic we, input logic [2:0] sz,
                                                 input int unsigned addr, input logic [31:0] wd);
        int unsigned idx;
        int unsigned lane;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] v;
        bit          bad;
        idx  = addr / 4;
        lane = addr % 4;
        bad  = (idx >= DEPTH)
            || (sz inside {3'd3, 3'd6, 3'd7})
            || (we && (sz inside {3'd4, 3'd5}))
            || ((sz == 3'd1 || sz == 3'd5) && (addr % 2 != 0))
            || (sz == 3'd2 && lane != 0);
        if (bad) return {1'b1, 32'h0};
        w = ref_mem[idx];
        if (we) begin
            case (sz)
                3'd0:    mask = 32'h0000_00FF << (8 * lane);
                3'd1:    mask = 32'h0000_FFFF << (8 * lane);
                default: mask = 32'hFFFF_FFFF;
            endcase
            ref_mem[idx] = (w & ~mask) | ((wd << (8 * lane)) & mask);
            return 33'h0;
        end
        v = w >> (8 * lane);
        case (sz)
            3'd0:    v = {{24{v[7]}}, v[7:0]};
            3'd4:    v = {24'h0, v[7:0]};
            3'd1:    v = {{16{v[15]}}, v[15:0]};
            3'd5:    v = {16'h0, v[15:0]};
            default: v = w;
        endcase
        return {1'b0, v};
    endfunction

    // Scoreboard: predict at each accepted request, compare half a cycle
    // after the following edge.
    always @(posedge clk) begin
        if (rst_n && bus.req_valid && bus.req_ready)
            exp_q.push_back(model_access(bus.req_we, bus.req_size, int'(bus.req_addr), bus.req_wdata));
    end

    always @(negedge clk) begin
        if (rst_n && (bus.rsp_valid || exp_q.size() != 0)) begin
            check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
            if (bus.rsp_valid && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e[32]));
                check("rsp_rdata", bus.rsp_rdata, mon_e[31:0]);
            end else begin
                exp_q.delete();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [2:0] sz,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_init(input bit poke);
        int cyc;
        bit early;
        cyc   = 0;
        early = 0;
        if (poke) begin
            // A store offered during INIT must be ignored entirely.
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_size  = SZ_W;
            bus.req_addr  = 10'h010;
            bus.req_wdata = 32'hBAD0_BAD0;
        end
        while (init_done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (init_done !== 1'b1 && bus.req_ready !== 1'b0) early = 1;
        end
        bus.req_valid = 1'b0;
        check("init_cycles", cyc, DEPTH);
        check("ready_during_init", 32'(early), 32'd0);
        check("ready_after_init", 32'(bus.req_ready), 32'd1);
        check("state_run", 32'(dbg_state), 32'(ST_RUN));
        @(negedge clk);
    endtask

    task automatic s_load(input logic [S_ADDR_W-1:0] a, input logic exp_err);
        sbus.req_valid = 1'b1;
        sbus.req_we    = 1'b0;
        sbus.req_size  = SZ_W;
        sbus.req_addr  = a;
        sbus.req_wdata = 32'h0;
        @(negedge clk);
        sbus.req_valid = 1'b0;
        check("s_rsp_valid", 32'(sbus.rsp_valid), 32'd1);
        check("s_rsp_err", 32'(sbus.rsp_err), 32'(exp_err));
        check("s_rsp_rdata", sbus.rsp_rdata, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [ADDR_W-1:0] ra;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_W;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        sbus.req_valid = 1'b0;
        sbus.req_we    = 1'b0;
        sbus.req_size  = SZ_W;
        sbus.req_addr  = '0;
        sbus.req_wdata = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_INIT));
        rst_n = 1'b1;
        wait_init(1);
        check("s_init_done", 32'(s_init_done), 32'd1);

        // Directed: first load, sub-word merge, extension.
        drive(0, SZ_W,  10'h010, 32'h0);
        drive(1, SZ_W,  10'h020, 32'h1122_3344);
        drive(1, SZ_B,  10'h021, 32'h0000_00F0);
        drive(0, SZ_W,  10'h020, 32'h0);
        drive(0, SZ_B,  10'h021, 32'h0);
        drive(0, SZ_BU, 10'h021, 32'h0);
        drive(0, SZ_H,  10'h022, 32'h0);
        drive(0, SZ_HU, 10'h020, 32'h0);
        idle();
        // Errors.
        drive(0, SZ_W,   10'h006, 32'h0);
        drive(1, SZ_H,   10'h003, 32'hABCD);
        drive(0, SZ_W,   10'h000, 32'h0);
        drive(0, 3'b011, 10'h000, 32'h0);
        drive(0, SZ_W,   10'h200, 32'h0);
        drive(1, SZ_BU,  10'h030, 32'hFF);
        drive(0, SZ_W,   10'h030, 32'h0);
        drive(0, SZ_W,   10'h1FC, 32'h0);
        idle();
        // Back-to-back store then load.
        drive(1, SZ_W, 10'h040, 32'hDEAD_BEEF);
        drive(0, SZ_W, 10'h040, 32'h0);
        idle();

        // Randomized traffic.
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                ra = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(512, 1023))
                                                 : ADDR_W'($urandom_range(0, 511));
                drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom());
            end
        end
        idle();
        idle();

        // Reset while a response is pending.
        drive(1, SZ_W, 10'h044, 32'h5555_AAAA);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_W;
        bus.req_addr  = 10'h010;
        @(posedge clk);
        #2;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rsp_reset_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rsp_reset_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rsp_reset_done", 32'(init_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again at sweep cycle 50.
        repeat (50) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_sweep_reset_done", 32'(init_done), 32'd0);
        check("mid_sweep_reset_state", 32'(dbg_state), 32'(ST_INIT));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init(0);

        // Sweep restored the fill pattern over earlier stores.
        drive(0, SZ_W, 10'h020, 32'h0);
        drive(0, SZ_W, 10'h040, 32'h0);
        drive(0, SZ_W, 10'h044, 32'h0);
        repeat (20) drive(0, SZ_W, ADDR_W'($urandom_range(0, DEPTH - 1) * 4), 32'h0);
        idle();

        // Zero-filled small instance and its range edge.
        for (int a = 0; a <= 'h3C; a += 4) s_load(S_ADDR_W'(a), 1'b0);
        s_load(7'h40, 1'b1);

        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
